// File: rtl/rv32i_exec_unit.sv
// RV32I execute stage: immediate decode, integer ALU and branch compare.
// Immediate is combinational; ALU result and branch decision are registered.
module rv32i_exec_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instr,
   input  logic [31:0] reg_data_1,
   input  logic [31:0] reg_data_2,
   input  logic        alu_en,
   input  logic        br_en,
   output logic [31:0] imm,
   output logic [31:0] alu_res,
   output logic        br_taken
);

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [31:0] op_a, op_b;
   logic [4:0]  shamt;
   logic [31:0] alu_nxt;
   logic        br_nxt;

   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];
   assign funct7 = instr[31:25];

   always_comb begin
      imm = '0;
      case (opcode)
         7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011:
            imm = {{20{instr[31]}}, instr[31:20]};
         7'b0100011:
            imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         7'b1100011:
            imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         7'b0110111, 7'b0010111:
            imm = {instr[31:12], 12'b0};
         7'b1101111:
            imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         default: imm = '0;
      endcase
   end

   // opcode[5] separates register-register (OP) from register-immediate (OP-IMM)
   assign op_a  = reg_data_1;
   assign op_b  = opcode[5] ? reg_data_2 : imm;
   assign shamt = op_b[4:0];

   always_comb begin
      alu_nxt = '0;
      case (funct3)
         3'b000: alu_nxt = (opcode[5] && funct7[5]) ? op_a - op_b : op_a + op_b;
         3'b001: alu_nxt = op_a << shamt;
         3'b010: alu_nxt = {31'b0, $signed(op_a) < $signed(op_b)};
         3'b011: alu_nxt = {31'b0, op_a < op_b};
         3'b100: alu_nxt = op_a ^ op_b;
         3'b101: alu_nxt = funct7[5] ? 32'($signed(op_a) >>> shamt) : op_a >> shamt;
         3'b110: alu_nxt = op_a | op_b;
         3'b111: alu_nxt = op_a & op_b;
         default: alu_nxt = '0;
      endcase
   end

   always_comb begin
      br_nxt = 1'b0;
      case (funct3)
         3'b000: br_nxt = (reg_data_1 == reg_data_2);
         3'b001: br_nxt = (reg_data_1 != reg_data_2);
         3'b100: br_nxt = ($signed(reg_data_1) <  $signed(reg_data_2));
         3'b101: br_nxt = ($signed(reg_data_1) >= $signed(reg_data_2));
         3'b110: br_nxt = (reg_data_1 <  reg_data_2);
         3'b111: br_nxt = (reg_data_1 >= reg_data_2);
         default: br_nxt = 1'b0;
      endcase
   end

   // Outputs clear whenever their enable drops, so results live only while held
   always_ff @(posedge clk) begin
      if (rst) begin
         alu_res  <= '0;
         br_taken <= 1'b0;
      end else begin
         alu_res  <= alu_en ? alu_nxt : '0;
         br_taken <= br_en ? br_nxt : 1'b0;
      end
   end

endmodule

// File: tb/tb_rv32i_exec_unit.sv
// Scoreboard bench for rv32i_exec_unit: driver queues hand-computed results,
// monitor checks them one cycle after each drive.
module tb_rv32i_exec_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] instr = '0;
   logic [31:0] reg_data_1 = '0;
   logic [31:0] reg_data_2 = '0;
   logic        alu_en = 1'b0;
   logic        br_en = 1'b0;
   logic [31:0] imm;
   logic [31:0] alu_res;
   logic        br_taken;

   int n_chk  = 0;
   int n_fail = 0;
   bit drv_done = 1'b0;

   typedef struct {
      string       name;
      logic [31:0] imm;
      bit          chk_imm;
      logic [31:0] alu;
      logic        br;
   } exp_t;

   exp_t sb[$];

   rv32i_exec_unit dut (
      .clk        (clk),
      .rst        (rst),
      .instr      (instr),
      .reg_data_1 (reg_data_1),
      .reg_data_2 (reg_data_2),
      .alu_en     (alu_en),
      .br_en      (br_en),
      .imm        (imm),
      .alu_res    (alu_res),
      .br_taken   (br_taken)
   );

   always #5 clk = ~clk;

   task automatic drive(input string name, input logic r, input logic [31:0] ins,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic ae, input logic be,
                        input bit ci, input logic [31:0] ei,
                        input logic [31:0] ea, input logic eb);
      exp_t e;
      @(negedge clk);
      rst = r; instr = ins; reg_data_1 = a; reg_data_2 = b; alu_en = ae; br_en = be;
      e.name = name; e.imm = ei; e.chk_imm = ci; e.alu = ea; e.br = eb;
      sb.push_back(e);
   endtask

   // Monitor: inputs are held from the negedge, so imm is still valid here
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.chk_imm) begin
               n_chk++;
               if (imm !== e.imm) begin
                  n_fail++;
                  $display("FAIL %s imm: got %h expected %h", e.name, imm, e.imm);
               end
            end
            n_chk++;
            if (alu_res !== e.alu) begin
               n_fail++;
               $display("FAIL %s alu_res: got %h expected %h", e.name, alu_res, e.alu);
            end
            n_chk++;
            if (br_taken !== e.br) begin
               n_fail++;
               $display("FAIL %s br_taken: got %b expected %b", e.name, br_taken, e.br);
            end
         end
      end
   end

   initial begin
      // reset with enables active
      drive("reset",     1, 32'h0000_0033, 32'd3, 32'd4, 1, 1, 0, 0, 32'h0, 0);
      drive("reset2",    1, 32'h0000_0033, 32'd3, 32'd4, 0, 0, 0, 0, 32'h0, 0);
      // immediate decode
      drive("imm_addi",  0, 32'hFFF0_0093, 0, 0, 0, 0, 1, 32'hFFFF_FFFF, 0, 0);
      drive("imm_sw",    0, 32'h00A1_2423, 0, 0, 0, 0, 1, 32'h0000_0008, 0, 0);
      drive("imm_beq",   0, 32'hFE00_08E3, 0, 0, 0, 0, 1, 32'hFFFF_FFF0, 0, 0);
      drive("imm_lui",   0, 32'h1234_50B7, 0, 0, 0, 0, 1, 32'h1234_5000, 0, 0);
      drive("imm_jal",   0, 32'h0080_00EF, 0, 0, 0, 0, 1, 32'h0000_0008, 0, 0);
      // register ALU ops, a=0x80000000 b=1
      drive("add",  0, 32'h0000_0033, 32'h8000_0000, 1, 1, 0, 1, 0, 32'h8000_0001, 0);
      drive("sub",  0, 32'h4000_0033, 32'h8000_0000, 1, 1, 0, 1, 0, 32'h7FFF_FFFF, 0);
      drive("slt",  0, 32'h0000_2033, 32'h8000_0000, 1, 1, 0, 1, 0, 32'h0000_0001, 0);
      drive("sltu", 0, 32'h0000_3033, 32'h8000_0000, 1, 1, 0, 1, 0, 32'h0000_0000, 0);
      drive("sra",  0, 32'h4000_5033, 32'h8000_0000, 1, 1, 0, 1, 0, 32'hC000_0000, 0);
      drive("srl",  0, 32'h0000_5033, 32'h8000_0000, 1, 1, 0, 1, 0, 32'h4000_0000, 0);
      drive("sll",  0, 32'h0000_1033, 32'h8000_0000, 1, 1, 0, 1, 0, 32'h0000_0000, 0);
      drive("xor",  0, 32'h0000_4033, 32'h8000_0000, 1, 1, 0, 1, 0, 32'h8000_0001, 0);
      drive("or",   0, 32'h0000_6033, 32'h8000_0000, 1, 1, 0, 1, 0, 32'h8000_0001, 0);
      drive("and",  0, 32'h0000_7033, 32'h8000_0000, 1, 1, 0, 1, 0, 32'h0000_0000, 0);
      // immediate ALU ops
      drive("addi_m1", 0, 32'hFFF0_0093, 32'd5, 32'h1234_5678, 1, 0, 1, 32'hFFFF_FFFF, 32'd4, 0);
      drive("srai1",   0, 32'h4010_5013, 32'hFFFF_FFF0, 32'h1234_5678, 1, 0, 1, 32'h0000_0401, 32'hFFFF_FFF8, 0);
      // branches, a=-1 b=1
      drive("beq",  0, 32'h0000_0063, 32'hFFFF_FFFF, 1, 0, 1, 0, 0, 0, 0);
      drive("bne",  0, 32'h0000_1063, 32'hFFFF_FFFF, 1, 0, 1, 0, 0, 0, 1);
      drive("blt",  0, 32'h0000_4063, 32'hFFFF_FFFF, 1, 0, 1, 0, 0, 0, 1);
      drive("bge",  0, 32'h0000_5063, 32'hFFFF_FFFF, 1, 0, 1, 0, 0, 0, 0);
      drive("bltu", 0, 32'h0000_6063, 32'hFFFF_FFFF, 1, 0, 1, 0, 0, 0, 0);
      drive("bgeu", 0, 32'h0000_7063, 32'hFFFF_FFFF, 1, 0, 1, 0, 0, 0, 1);
      drive("br010",0, 32'h0000_2063, 32'hFFFF_FFFF, 1, 0, 1, 0, 0, 0, 0);
      drive("beq_eq",0,32'h0000_0063, 32'd7, 32'd7, 0, 1, 0, 0, 0, 1);
      // enable / reset interaction
      drive("en_on",   0, 32'h0000_0033, 32'd3, 32'd4, 1, 0, 0, 0, 32'd7, 0);
      drive("en_off",  0, 32'h0000_0033, 32'd3, 32'd4, 0, 0, 0, 0, 32'd0, 0);
      drive("both_on", 0, 32'h0000_0033, 32'd3, 32'd3, 1, 1, 0, 0, 32'd6, 1);
      drive("rst_mid", 1, 32'h0000_0033, 32'd3, 32'd3, 1, 1, 0, 0, 32'd0, 0);
      drive("rst_rel", 0, 32'h0000_0033, 32'd3, 32'd3, 1, 1, 0, 0, 32'd6, 1);
      drive("br_drop", 0, 32'h0000_0033, 32'd3, 32'd3, 1, 0, 0, 0, 32'd6, 0);
      @(negedge clk);
      alu_en = 1'b0; br_en = 1'b0;
      drv_done = 1'b1;
   end

   initial begin
      int waited;
      waited = 0;
      while (!drv_done && waited < 1000) begin
         @(negedge clk);
         waited++;
      end
      repeat (3) @(negedge clk);
      n_chk++;
      if (!drv_done || sb.size() != 0) begin
         n_fail++;
         $display("FAIL drain: done=%0b pending=%0d expected done=1 pending=0", drv_done, sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
